// File: rtl/ulut_bank.sv
// Bank of CHANNELS registered K-input universal gates with shadow/active truth tables.
// Optional macro ULUT_FEEDBACK_EN adds fb_en: per-channel feedback of out_data into input bit 0.

module ulut_lane #(
  parameter int K  = 3,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          fb_en,
  input  logic [TW-1:0] tbl,
  input  logic [K-1:0]  idx,
  output logic          out_q
);
  logic [K-1:0] idx_eff;

  always_comb begin
    idx_eff = idx;
    if (fb_en) idx_eff[0] = out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        out_q <= 1'b0;
    else if (in_valid) out_q <= tbl[idx_eff];
  end
endmodule

module ulut_bank #(
  parameter int CHANNELS = 4,
  parameter int K        = 3,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SEL_W-1:0]      cfg_chan,
  input  logic [(1<<K)-1:0]     cfg_data,
  input  logic                  cfg_commit,
  output logic                  cfg_dirty,
`ifdef ULUT_FEEDBACK_EN
  input  logic [CHANNELS-1:0]   fb_en,
`endif
  input  logic                  in_valid,
  input  logic [CHANNELS*K-1:0] in_data,
  output logic                  out_valid,
  output logic [CHANNELS-1:0]   out_data,
  input  logic [SEL_W-1:0]      mux_sel,
  output logic                  mux_out
);
  localparam int TW     = 1 << K;
  localparam int STAGES = 1;

  typedef enum logic {S_LOAD, S_COMMIT} state_t;

  state_t                      state_q, state_d;
  logic                        rdy_q;
  logic                        cfg_fire;
  logic [CHANNELS-1:0]         chan_hit;
  logic [CHANNELS-1:0][TW-1:0] shadow, active;
  logic [CHANNELS-1:0]         fb_vec;
  logic [STAGES:0]             vld_pipe;

`ifdef ULUT_FEEDBACK_EN
  assign fb_vec = fb_en;
`else
  assign fb_vec = '0;
`endif

  // rdy_q keeps cfg_ready low through reset and the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  assign cfg_ready = rdy_q && (state_q == S_LOAD);

  always_comb begin
    state_d  = state_q;
    cfg_fire = 1'b0;
    case (state_q)
      S_LOAD: begin
        cfg_fire = cfg_valid && cfg_ready;
        if (cfg_commit) state_d = S_COMMIT;
      end
      S_COMMIT: state_d = S_LOAD;
      default:  state_d = S_LOAD;
    endcase
  end

  always_comb begin
    chan_hit = '0;
    for (int i = 0; i < CHANNELS; i++) chan_hit[i] = (cfg_chan == SEL_W'(i));
  end

  // Out-of-range channels match no lane, so the write is silently dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      active    <= '0;
      cfg_dirty <= 1'b0;
    end else begin
      if (cfg_fire) begin
        for (int i = 0; i < CHANNELS; i++)
          if (chan_hit[i]) shadow[i] <= cfg_data;
        if (|chan_hit) cfg_dirty <= 1'b1;
      end
      if (state_q == S_COMMIT) begin
        active    <= shadow;
        cfg_dirty <= 1'b0;
      end
    end
  end

  assign vld_pipe[0] = in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  assign out_valid = vld_pipe[STAGES];

  // Lanes sample active in the COMMIT cycle before it updates: no mixed tables
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    ulut_lane #(.K(K), .TW(TW)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .fb_en    (fb_vec[g]),
      .tbl      (active[g]),
      .idx      (in_data[g*K +: K]),
      .out_q    (out_data[g])
    );
  end

  always_comb begin
    mux_out = 1'b0;
    for (int i = 0; i < CHANNELS; i++)
      if (mux_sel == SEL_W'(i)) mux_out = out_data[i];
  end
endmodule

// File: doc/ulut_bank.md
Name: ulut_bank

Overview:
- Parametrised, registered successor to the fixed-size combinational universal gates.
- Holds CHANNELS independent K-input universal gates, each defined by a 2^K-bit truth table.
- Truth tables are written through a valid/ready config port into shadow registers and committed atomically.
- The data path is a registered 1-cycle pipeline with a selectable output mux. It sits between the chip's I/O/logic-analyser pins and user logic as a reconfigurable logic fabric tile.

Parameters:
- CHANNELS, 4, number of independent universal gates (1..16)
- K, 3, inputs per gate (1..5); truth-table width TW = 2^K
- SEL_W, clog2(CHANNELS) (min 1), width of channel select fields

Ports:
- clk  input  1  sole clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- cfg_valid  input  1  config write request
- cfg_ready  output  1  config port can accept a write this cycle
- cfg_chan  input  SEL_W  target channel of the config write
- cfg_data  input  TW  truth table for cfg_chan
- cfg_commit  input  1  pulse: copy all shadow tables to active tables
- cfg_dirty  output  1  shadow differs from active (an uncommitted write exists)
- in_valid  input  1  data input qualifier
- in_data  input  CHANNELS*K  gate inputs; channel i uses bits [i*K +: K]
- out_valid  output  1  registered qualifier of out_data
- out_data  output  CHANNELS  registered gate outputs, bit i = channel i
- mux_sel  input  SEL_W  selects one channel of out_data
- mux_out  output  1  combinational out_data[mux_sel]; 0 if mux_sel >= CHANNELS

Behaviour:
- Reset (async assert, sync-safe deassert): shadow and active tables = 0; out_data = 0; out_valid = 0; cfg_dirty = 0; FSM = LOAD; cfg_ready = 0 while rst_n low, 1 in LOAD.
- Config FSM, two states:
  - LOAD: cfg_ready = 1. A write fires when cfg_valid && cfg_ready: shadow[cfg_chan] <= cfg_data and cfg_dirty <= 1. A write with cfg_chan >= CHANNELS is accepted and discarded (no dirty change). cfg_commit = 1 -> COMMIT.
  - COMMIT (exactly 1 cycle): cfg_ready = 0. Active <= shadow for all channels; cfg_dirty <= 0; then -> LOAD.
  - cfg_commit and a write in the same LOAD cycle: the write lands in shadow first and is included in the commit.
  - cfg_commit asserted while in COMMIT: ignored.
- Data path:
  - On in_valid: out_data[i] <= active[i][in_data[i*K +: K]]; out_valid <= 1.
  - On !in_valid: out_valid <= 0; out_data holds its last value.
  - Latency is 1 cycle, full throughput, no backpressure.
- Config/data ordering: data sampled in the COMMIT cycle uses the old active tables. Data sampled from the cycle after COMMIT onward uses the new tables. No output ever mixes old and new tables across channels.
- Truth-table indexing: input vector value v selects table bit v (LSB = all-zero inputs).

Optional Feature:
- Macro: ULUT_FEEDBACK_EN.
- When defined:
  - Extra port fb_en (input, CHANNELS bits).
  - For each channel i with fb_en[i] = 1, gate input bit 0 is replaced by the channel's own registered out_data[i]. This turns the channel into a 1-bit state machine (toggle, latch, counter stage).
  - Feedback updates only when in_valid = 1.
  - On reset, feedback state is 0.
- When undefined: no fb_en port; all inputs come from in_data.

Test Plan:
- Reset -> out_data = 0, out_valid = 0, cfg_ready = 0 during reset, cfg_ready = 1 one cycle after release, cfg_dirty = 0.
- Write ch0 = 0x96 (XOR3), ch1 = 0xE8 (MAJ3), then commit; in_data ch0 = 3'b111, ch1 = 3'b011 with in_valid -> next cycle out_data[1:0] = 2'b11, out_valid = 1, cfg_dirty back to 0.
- With ch0 active = 0x96, write ch0 = 0x00 without commit; drive ch0 = 3'b111 -> output 1, cfg_dirty = 1. After commit and one cycle -> output 0.
- Hold in_valid = 1 across a commit that changes ch2 from 0xFF to 0x00 -> the COMMIT-cycle sample gives 1, the next-cycle sample gives 0; cfg_ready = 0 exactly one cycle.
- mux_sel sweep 0..3 with out_data = 4'b1010 -> mux_out = 0, 1, 0, 1. Write with cfg_chan = 3 when CHANNELS = 3 -> discarded, cfg_dirty unchanged.
- (ULUT_FEEDBACK_EN) ch0 = 0x55 (NOT of input bit 0), fb_en[0] = 1, in_valid = 1 for 4 cycles -> out_data[0] = 1, 0, 1, 0. Deassert rst_n mid-sequence -> out_data[0] = 0 immediately.
